rr_decode_arbiter: RTL and testbench
====================================

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of GRANT cycles before a forced release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: active-high arbitration enable.
REQ-005 The block SHALL have port req, input, 16 bits: active-high request per requester 0..15.
REQ-006 The block SHALL have port done, input, 1 bit: active-high release pulse from the current grantee.
REQ-007 The block SHALL have port grant_n, output, 16 bits: active-low one-hot grant; all ones means no grant.
REQ-008 The block SHALL have port grant_idx, output, 4 bits: index of the current or last grantee.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in GRANT.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-012 In IDLE, at a rising edge with en=1 and req!=0, the block SHALL select a winner and enter GRANT; otherwise it SHALL stay in IDLE.
REQ-013 The winner SHALL be the first set req bit searching upward from the pointer ptr, wrapping from 15 to 0.
REQ-014 The winner SHALL be registered into grant_idx on the same edge that enters GRANT.
REQ-015 grant_n SHALL be the active-low decode of grant_idx when in GRANT, and all ones in IDLE and GAP.
REQ-016 grant_n SHALL be driven from registers only, with no combinational path from req.
REQ-017 Grant latency SHALL be one edge: req sampled at edge N means grant_n is low after edge N.
REQ-018 In GRANT, the grant SHALL release at an edge where done=1 or req[grant_idx]=0, entering GAP.
REQ-019 In GRANT, a 9-bit counter SHALL count GRANT cycles; at the edge where it reaches TIMEOUT_CYC without release, the block SHALL enter GAP and pulse timeout for exactly one cycle.
REQ-020 If done and timeout coincide on the same edge, done SHALL win and timeout SHALL stay low.
REQ-021 On any release, ptr SHALL become grant_idx+1 modulo 16, so 15 wraps to 0.
REQ-022 GAP SHALL last exactly one cycle, with all grant_n high.
REQ-023 On leaving GAP, the block SHALL arbitrate exactly as in IDLE, so back-to-back grants are separated by exactly one idle cycle.
REQ-024 en=0 SHALL block only new grants; a grant in progress SHALL run to release.
REQ-025 done in IDLE or GAP SHALL be ignored.
REQ-026 req changes on non-granted bits during GRANT SHALL have no effect.

Reset
REQ-027 When reset_n=0, the block SHALL immediately, independent of clk, set: state IDLE, grant_n 16'hFFFF, grant_idx 0, ptr 0, counter 0, busy 0, timeout 0.
REQ-028 A reset asserted mid-GRANT SHALL drop the grant in the same cycle, with no GAP and no timeout pulse.
REQ-029 The first arbitration after reset release SHALL occur at the first rising edge with reset_n=1.

Structure
REQ-030 The FSM state encodings (IDLE=2'b00, GRANT=2'b01, GAP=2'b10) and the default TIMEOUT_CYC SHALL live in the shared package arb_pkg.
REQ-031 The active-low 4-to-16 decode SHALL be a separate sub-module, grant_decoder (inputs en, in[3:0]; output out[15:0]), instantiated once with en tied to the GRANT-state flag.
REQ-032 The priority search SHALL be combinational logic inside rr_decode_arbiter.

Verification
REQ-033 Scenario: reset; req=16'h0001 at edge 1, done at edge 5 -> grant_n=16'hFFFE after edges 1..4, 16'hFFFF after edge 5 (GAP), ptr=1.
REQ-034 Scenario: req=16'h8001 held with done each grant -> grants alternate idx 0, 15, 0, 15, each separated by one GAP cycle (wrap check).
REQ-035 Scenario: TIMEOUT_CYC=4, req=16'h0010, no done -> grant idx 4 for 4 cycles, timeout high for one cycle, then regrant idx 4 after GAP.
REQ-036 Scenario: grant idx 3 active, reset_n pulled low mid-cycle -> grant_n=16'hFFFF immediately and busy=0 before the next edge.
REQ-037 Scenario: en=0 with req=16'hFFFF -> no grant; raise en during an existing grant, drop req[grant_idx] -> release, then next idx is grant_idx+1.
REQ-038 Scenario: done and timeout on the same edge -> GAP entered and timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encodings and defaults for the round-robin grant arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;
  localparam int unsigned N_REQ               = 16;
  localparam int unsigned CNT_W               = 9;

endpackage

// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - active-low 4-to-16 one-hot decoder with enable
module grant_decoder (
  input  logic        en,
  input  logic [3:0]  in,
  output logic [15:0] out
);

  always_comb begin
    out = 16'hFFFF;
    if (en) begin
      out[in] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 16-way round-robin arbiter with one-cycle gap and grant timeout
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant_n,
  output logic [3:0]  grant_idx,
  output logic        busy,
  output logic        timeout
);

  arb_state_e       state_q, state_d;
  logic [3:0]       grant_idx_q, grant_idx_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       winner;
  logic             found;
  logic [CNT_W-1:0] cnt_inc;
  logic             rel_now;
  logic             timeout_hit;
  logic             in_grant;

  // First requester at or above ptr, wrapping through 15 -> 0.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req[ptr_q + 4'(i)]) begin
        found  = 1'b1;
        winner = ptr_q + 4'(i);
      end
    end
  end

  assign cnt_inc     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign rel_now     = done || !req[grant_idx_q];
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      GRANT: begin
        cnt_d = cnt_inc;
        // A real release takes precedence over an expiring counter.
        if (rel_now) begin
          state_d = GAP;
          ptr_d   = grant_idx_q + 4'd1;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d   = GAP;
          ptr_d     = grant_idx_q + 4'd1;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        if (en && found) begin
          state_d     = GRANT;
          grant_idx_d = winner;
          cnt_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= 4'd0;
      ptr_q       <= 4'd0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign busy      = in_grant;
  assign timeout   = timeout_q;
  assign grant_idx = grant_idx_q;

  grant_decoder u_grant_decoder (
    .en  (in_grant),
    .in  (grant_idx_q),
    .out (grant_n)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - scoreboard bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

  localparam int TO = 4;
  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_GAP   = 2;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant_n;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        timeout;

  typedef struct {
    logic [15:0] gn;
    logic [3:0]  gi;
    logic        b;
    logic        t;
  } exp_t;

  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  int m_state;
  int m_idx;
  int m_ptr;
  int m_held;
  int m_to;

  rr_decode_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .grant_n   (grant_n),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_idx   = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 0;
  endtask

  // Reference: what the arbiter must look like after one rising edge with these inputs.
  task automatic model_edge(input logic e, input logic [15:0] r, input logic d);
    exp_t x;
    m_to = 0;
    if (m_state == M_GRANT) begin
      m_held = m_held + 1;
      if (d || !r[m_idx]) begin
        m_state = M_GAP;
        m_ptr   = (m_idx + 1) % 16;
      end else if (m_held == TO) begin
        m_state = M_GAP;
        m_ptr   = (m_idx + 1) % 16;
        m_to    = 1;
      end
    end else begin
      m_state = M_IDLE;
      if (e && r != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (m_state != M_GRANT && r[(m_ptr + k) % 16]) begin
            m_idx   = (m_ptr + k) % 16;
            m_state = M_GRANT;
            m_held  = 0;
          end
        end
      end
    end
    x.b  = (m_state == M_GRANT);
    x.gn = x.b ? ~(16'h1 << m_idx) : 16'hFFFF;
    x.gi = 4'(m_idx);
    x.t  = (m_to != 0);
    exp_q.push_back(x);
  endtask

  task automatic cycle(input logic e, input logic [15:0] r, input logic d);
    @(negedge clk);
    reset_n = 1'b1;
    en      = e;
    req     = r;
    done    = d;
    model_edge(e, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 16'h0;
    done    = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_grant_n", 32'(grant_n), 32'hFFFF);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_grant_n", 32'(grant_n), 32'(e.gn));
        check("sb_grant_idx", 32'(grant_idx), 32'(e.gi));
        check("sb_busy", 32'(busy), 32'(e.b));
        check("sb_timeout", 32'(timeout), 32'(e.t));
      end
    end
  end

  initial begin : stim
    logic [15:0] cur_req;
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 16'h0;
    done    = 1'b0;
    model_reset();
    #3;
    check("por_grant_n", 32'(grant_n), 32'hFFFF);
    check("por_grant_idx", 32'(grant_idx), 32'h0);
    check("por_busy", 32'(busy), 32'h0);
    check("por_timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    #1;

    // single requester, done after four grant cycles, pointer moves to 1
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h0001, 1'b0);
      check("s33_grant", 32'(grant_n), 32'hFFFE);
    end
    cycle(1'b1, 16'h0001, 1'b1);
    check("s33_gap", 32'(grant_n), 32'hFFFF);
    check("s33_gap_to", 32'(timeout), 32'h0);
    cycle(1'b1, 16'h0003, 1'b0);
    check("s33_ptr1", 32'(grant_idx), 32'h1);

    // wrap between 0 and 15
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 16'h8001, 1'b0);
      check("s34_idx0", 32'(grant_idx), 32'h0);
      check("s34_gn0", 32'(grant_n), 32'hFFFE);
      cycle(1'b1, 16'h8001, 1'b1);
      check("s34_gap_a", 32'(grant_n), 32'hFFFF);
      cycle(1'b1, 16'h8001, 1'b0);
      check("s34_idx15", 32'(grant_idx), 32'hF);
      check("s34_gn15", 32'(grant_n), 32'h7FFF);
      cycle(1'b1, 16'h8001, 1'b1);
      check("s34_gap_b", 32'(busy), 32'h0);
    end

    // forced release after TO cycles, then regrant of the same requester
    do_reset();
    for (int i = 0; i < TO; i++) begin
      cycle(1'b1, 16'h0010, 1'b0);
      check("s35_busy", 32'(busy), 32'h1);
      check("s35_to_low", 32'(timeout), 32'h0);
    end
    cycle(1'b1, 16'h0010, 1'b0);
    check("s35_to_pulse", 32'(timeout), 32'h1);
    check("s35_gap", 32'(grant_n), 32'hFFFF);
    cycle(1'b1, 16'h0010, 1'b0);
    check("s35_to_clear", 32'(timeout), 32'h0);
    check("s35_regrant", 32'(grant_idx), 32'h4);

    // done coincides with the timeout edge
    do_reset();
    for (int i = 0; i < TO; i++) cycle(1'b1, 16'h0010, 1'b0);
    cycle(1'b1, 16'h0010, 1'b1);
    check("s38_no_to", 32'(timeout), 32'h0);
    check("s38_gap", 32'(busy), 32'h0);

    // enable only gates new grants
    do_reset();
    cycle(1'b0, 16'hFFFF, 1'b0);
    cycle(1'b0, 16'hFFFF, 1'b0);
    check("s37_no_grant", 32'(grant_n), 32'hFFFF);
    cycle(1'b1, 16'hFFFF, 1'b0);
    check("s37_idx0", 32'(grant_idx), 32'h0);
    cycle(1'b0, 16'hFFFF, 1'b0);
    check("s37_holds", 32'(busy), 32'h1);
    cycle(1'b0, 16'hFFFE, 1'b0);
    check("s37_release", 32'(busy), 32'h0);
    cycle(1'b1, 16'hFFFE, 1'b0);
    check("s37_next", 32'(grant_n), 32'hFFFD);

    // asynchronous reset in the middle of a grant
    do_reset();
    cycle(1'b1, 16'h0008, 1'b0);
    check("s36_idx3", 32'(grant_idx), 32'h3);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("s36_gn_drop", 32'(grant_n), 32'hFFFF);
    check("s36_busy_drop", 32'(busy), 32'h0);
    check("s36_idx_clr", 32'(grant_idx), 32'h0);
    check("s36_no_to", 32'(timeout), 32'h0);

    // randomized traffic against the reference model
    cur_req = 16'h0;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 15))
        0, 1:    cur_req = 16'($urandom);
        2:       cur_req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        3:       cur_req = 16'h0;
        4, 5:    cur_req[$urandom_range(0, 15)] = ~cur_req[$urandom_range(0, 15)];
        default: ;
      endcase
      cycle($urandom_range(0, 9) != 0, cur_req, $urandom_range(0, 5) == 0);
    end

    @(posedge clk);
    #2;
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
